// File: rtl/conv_sched.sv
// conv_sched: per-tile sequencer for the 32-layer parallel conv array.
// Clears the accumulators, streams image/weight reads under conv_en, drains, then hands off each psum tile.
module conv_sched #(
   parameter int IMG_AW   = 10,
   parameter int WGT_AW   = 8,
   parameter int ACC_W    = 8,
   parameter int TILE_W   = 16,
   parameter int CONV_LAT = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [ACC_W-1:0]  i_cfg_acc_len,
   input  logic [TILE_W-1:0] i_cfg_tiles,
   input  logic [IMG_AW-1:0] i_cfg_img_base,
   input  logic [WGT_AW-1:0] i_cfg_wgt_base,
   output logic              o_img_rd_en,
   output logic [IMG_AW-1:0] o_img_rd_addr,
   output logic              o_wgt_rd_en,
   output logic [WGT_AW-1:0] o_wgt_rd_addr,
   output logic              o_conv_en,
   output logic              o_psum_clr,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [TILE_W-1:0] o_tile_idx,
   output logic              o_busy,
   output logic              o_done
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_OUT   = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   // Drain covers one buffer cycle plus the array latency.
   localparam int               DRN_W    = $clog2(CONV_LAT + 2);
   localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(CONV_LAT);

   logic [2:0]        r_state;
   logic [ACC_W-1:0]  r_acc_len;
   logic [TILE_W-1:0] r_tiles;
   logic [IMG_AW-1:0] r_img_base;
   logic [WGT_AW-1:0] r_wgt_base;
   logic [ACC_W-1:0]  r_k;
   logic [DRN_W-1:0]  r_drn;
   logic [IMG_AW-1:0] r_img_off;
   logic [TILE_W-1:0] r_tile_idx;
   logic              r_rd_en;
   logic [IMG_AW-1:0] r_img_addr;
   logic [WGT_AW-1:0] r_wgt_addr;
   logic              r_conv_en;
   logic              r_psum_clr;
   logic              r_out_valid;
   logic              r_busy;
   logic              r_done;

   logic [2:0]        w_state_nxt;
   logic [ACC_W-1:0]  w_k_nxt;
   logic [DRN_W-1:0]  w_drn_nxt;
   logic [IMG_AW-1:0] w_off_nxt;
   logic [TILE_W-1:0] w_tile_nxt;
   logic              w_latch;
   logic              w_hs;
   logic              w_last_tile;
   logic [IMG_AW-1:0] w_img_addr_nxt;
   logic [WGT_AW-1:0] w_wgt_addr_nxt;

   assign w_hs        = r_out_valid & i_out_ready;
   assign w_last_tile = ((r_tile_idx + TILE_W'(1)) == r_tiles);

   // Image address uses a running per-tile offset instead of tile_idx*acc_len.
   assign w_img_addr_nxt = r_img_base + r_img_off + IMG_AW'(w_k_nxt);
   assign w_wgt_addr_nxt = r_wgt_base + WGT_AW'(w_k_nxt);

   // Next-state and counter update logic.
   always_comb begin
      w_state_nxt = r_state;
      w_k_nxt     = r_k;
      w_drn_nxt   = r_drn;
      w_off_nxt   = r_img_off;
      w_tile_nxt  = r_tile_idx;
      w_latch     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_latch    = 1'b1;
               w_off_nxt  = '0;
               w_tile_nxt = '0;
               if ((i_cfg_acc_len == '0) || (i_cfg_tiles == '0)) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_state_nxt = S_CLEAR;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_CLEAR: begin
            w_state_nxt = S_RUN;
            w_k_nxt     = '0;
         end
         S_RUN: begin
            if (r_k == (r_acc_len - ACC_W'(1))) begin
               w_state_nxt = S_DRAIN;
               w_drn_nxt   = '0;
            end else begin
               w_k_nxt = r_k + ACC_W'(1);
            end
         end
         S_DRAIN: begin
            if (r_drn == DRN_LAST) begin
               w_state_nxt = S_OUT;
            end else begin
               w_drn_nxt = r_drn + DRN_W'(1);
            end
         end
         S_OUT: begin
            if (w_hs) begin
               if (w_last_tile) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_state_nxt = S_CLEAR;
                  w_tile_nxt  = r_tile_idx + TILE_W'(1);
                  w_off_nxt   = r_img_off + IMG_AW'(r_acc_len);
               end
            end else begin
               w_state_nxt = S_OUT;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
            w_tile_nxt  = '0;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_tile_nxt  = '0;
         end
      endcase
   end

   // State, job configuration and loop counters.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_acc_len  <= '0;
         r_tiles    <= '0;
         r_img_base <= '0;
         r_wgt_base <= '0;
         r_k        <= '0;
         r_drn      <= '0;
         r_img_off  <= '0;
         r_tile_idx <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_k        <= w_k_nxt;
         r_drn      <= w_drn_nxt;
         r_img_off  <= w_off_nxt;
         r_tile_idx <= (w_state_nxt == S_DONE) ? '0 : w_tile_nxt;
         if (w_latch) begin
            r_acc_len  <= i_cfg_acc_len;
            r_tiles    <= i_cfg_tiles;
            r_img_base <= i_cfg_img_base;
            r_wgt_base <= i_cfg_wgt_base;
         end
      end
   end

   // Registered outputs, decoded from the state being entered.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rd_en     <= 1'b0;
         r_img_addr  <= '0;
         r_wgt_addr  <= '0;
         r_conv_en   <= 1'b0;
         r_psum_clr  <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_rd_en     <= (w_state_nxt == S_RUN);
         r_conv_en   <= r_rd_en;
         r_psum_clr  <= (w_state_nxt == S_CLEAR);
         r_out_valid <= (w_state_nxt == S_OUT);
         r_busy      <= (w_state_nxt != S_IDLE);
         r_done      <= (w_state_nxt == S_DONE);
         if (w_state_nxt == S_RUN) begin
            r_img_addr <= w_img_addr_nxt;
            r_wgt_addr <= w_wgt_addr_nxt;
         end
      end
   end

   assign o_img_rd_en   = r_rd_en;
   assign o_wgt_rd_en   = r_rd_en;
   assign o_img_rd_addr = r_img_addr;
   assign o_wgt_rd_addr = r_wgt_addr;
   assign o_conv_en     = r_conv_en;
   assign o_psum_clr    = r_psum_clr;
   assign o_out_valid   = r_out_valid;
   assign o_tile_idx    = r_tile_idx;
   assign o_busy        = r_busy;
   assign o_done        = r_done;

endmodule
